mips32i_mc_ctrl: RTL and testbench
==================================

Name: mips32i_mc_ctrl

Overview:
Multi-cycle control unit for the MIPS32i datapath. It extends the single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB state machine and a mem_req/mem_ack handshake to variable-latency memory. It adds JR/JALR, illegal-opcode and memory-timeout traps, and a sticky halt. It sits between the instruction register/ALU flags and the datapath enables and muxes.

Parameters:
MEM_TIMEOUT, 16, max wait cycles per memory access before trap; 0 disables the timeout.
CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.
EN_JR, 1, 1 decodes JR/JALR; 0 treats funct 001000/001001 as illegal.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
instr  in  32  instruction register contents, valid from DECODE onward
alu_zero  in  1  ALU zero flag, sampled in EXEC
mem_ack  in  1  memory completes the current request this cycle
state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7
aluop  out  6  ALU operation, registered in DECODE
inst_type_R0_I1  out  1  ALU B source: 0 = register, 1 = immediate
imm_signext0_zeroext1  out  1  immediate extension mode
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write request (valid with mem_req)
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_wt_en  out  1  load IR
pc_wt_en  out  1  load PC
next_PC_ctrl  out  3  0 = PC+4, 1 = J target, 2 = branch target, 3 = rs (JR)
reg_wt_en  out  1  register file write strobe
reg_wt_sel  out  2  0 = ALU, 1 = MEM, 2 = PC+4 (link)
reg_dst_sel  out  2  0 = rt, 1 = rd, 2 = $31
trap  out  1  sticky, 1 in TRAP
exc_code  out  2  0 = none, 1 = illegal opcode, 2 = fetch timeout, 3 = data timeout

Behaviour:
- Reset: state=FETCH, wait counter=0, every output 0, exc_code=0. Reset wins over all other events, including in TRAP.
- Strobes (ir_wt_en, pc_wt_en, reg_wt_en) pulse for exactly one cycle. All other decode outputs are registered and hold until the next DECODE.
- FETCH: mem_req=1, mem_we=0, mem_addr_sel=0. On mem_ack: ir_wt_en=1, pc_wt_en=1, next_PC_ctrl=0, go to DECODE. Otherwise increment the counter.
- DECODE: register the decode fields from instr[31:26]/[5:0].
  - R-type: aluop=funct, inst_type_R0_I1=0, reg_dst_sel=1.
  - beq/bne (00010x): aluop=100010, inst_type_R0_I1=0.
  - load/store (10xxxx): aluop=100000.
  - SLTI/SLTIU (00101x): aluop={10,op[3:0]}.
  - LUI: aluop=101111.
  - Other I-type: aluop={100,op[2:0]}, reg_dst_sel=0.
  - Zero-extend when op[5:2]=0011 or op[5:1]=10000.
  - J/JAL (00001x): pc_wt_en=1, next_PC_ctrl=1. JAL also sets reg_wt_en=1, reg_wt_sel=2, reg_dst_sel=2. Return to FETCH.
  - JR/JALR (EN_JR=1): pc_wt_en=1, next_PC_ctrl=3. JALR also writes PC+4 to rd. Return to FETCH.
  - Unsupported opcode/funct: TRAP, exc_code=1.
  - Otherwise go to EXEC.
- EXEC:
  - Branch: pc_wt_en = (beq ? alu_zero : !alu_zero), next_PC_ctrl=2, then FETCH. Branch target uses PC already incremented in FETCH.
  - Load/store: go to MEM.
  - Else: go to WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=op[3]. On mem_ack: store goes to FETCH; load goes to WB with reg_wt_sel=1.
- WB: reg_wt_en=1 for one cycle, then FETCH.
- Timeout: the counter clears on every state entry. If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT without mem_ack, go to TRAP with exc_code 2 (FETCH) or 3 (MEM). mem_ack arriving in the same cycle as the limit completes normally (ack wins).
- TRAP: all strobes and mem_req are 0, trap=1. Held until rst.
- mem_ack outside FETCH/MEM is ignored.
- Latency in cycles, with 1-cycle ack: ALU op 4, load 5, store 4, branch 3, jump 2.

Decomposition:
- Shared package mips32i_pkg holds:
  - state encoding
  - opcode/funct constants (R, J, JAL, BEQ, BNE, LW, SW, LUI, SLTI, JR, JALR)
  - aluop constants
  - next_PC_ctrl, reg_wt_sel, reg_dst_sel and exc_code enums
- One sub-module, mips32i_decode: combinational decode of instr to aluop, immediate mode, class (R/I/branch/load/store/jump/jr/illegal) and destination. The FSM wraps it and registers its outputs.

Test Plan:
- ADD (op 0, funct 100000), ack in 1 cycle -> states 0,1,2,4,0. aluop=100000, reg_dst_sel=1, one reg_wt_en pulse in WB.
- LW with data ack delayed 3 cycles -> mem_req held 4 cycles with mem_addr_sel=1, mem_we=0. WB has reg_wt_sel=1 and one reg_wt_en pulse.
- BNE, first with alu_zero=1 and then with alu_zero=0 -> pc_wt_en=0, then pc_wt_en=1 with next_PC_ctrl=2. Each returns to FETCH after EXEC.
- JAL -> in DECODE: pc_wt_en=1, next_PC_ctrl=1, reg_wt_en=1, reg_wt_sel=2, reg_dst_sel=2. Next state FETCH.
- Opcode 111111 -> TRAP, trap=1, exc_code=1, no further strobes. rst=1 for one cycle returns to FETCH with all outputs 0.
- MEM_TIMEOUT=4, no fetch ack -> TRAP after 4 wait cycles, exc_code=2. Repeat with ack on the 4th cycle -> normal DECODE.

Source files
------------

// File: rtl/mips32i_pkg.sv
// Shared definitions for the MIPS32i multi-cycle control slice: state encoding,
// opcode/funct and ALU constants, and the decode record passed to the FSM.
package mips32i_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_LUI = 6'b101111;

  typedef enum logic [2:0] {NPC_SEQ = 3'd0, NPC_JUMP = 3'd1, NPC_BRANCH = 3'd2, NPC_REG = 3'd3} npc_sel_e;
  typedef enum logic [1:0] {WSEL_ALU = 2'd0, WSEL_MEM = 2'd1, WSEL_LINK = 2'd2} wb_sel_e;
  typedef enum logic [1:0] {DST_RT = 2'd0, DST_RD = 2'd1, DST_R31 = 2'd2} reg_dst_e;
  typedef enum logic [1:0] {EXC_NONE = 2'd0, EXC_ILLEGAL = 2'd1, EXC_FETCH_TO = 2'd2, EXC_DATA_TO = 2'd3} exc_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_JUMP, CLS_JR, CLS_ILLEGAL
  } cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [5:0] aluop;
    logic       alu_imm;  // ALU B source is the immediate
    logic       zext;
    reg_dst_e   dst;
    wb_sel_e    wsel;
    logic       bne;      // branch taken on !zero rather than zero
  } dec_t;

  function automatic logic r_funct_legal(input logic [5:0] funct);
    return funct inside {6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110,
                         6'b000111, [6'b100000:6'b100111], 6'b101010, 6'b101011};
  endfunction

endpackage

// File: rtl/mips32i_decode.sv
// Combinational instruction decode: opcode/funct to ALU op, immediate mode,
// instruction class and write-back destination.
module mips32i_decode
  import mips32i_pkg::*;
#(
  parameter int EN_JR = 1
) (
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  // NOTE: every field gets a default before the decode tree so that no
  // path leaves a bit unassigned and infers a latch.
  always_comb begin
    dec      = '0;
    dec.cls  = CLS_ILLEGAL;
    dec.zext = (op[5:2] == 4'b0011) || (op[5:1] == 5'b10000);

    if (op == OP_R) begin
      dec.aluop = funct;
      dec.dst   = DST_RD;
      if (funct == FN_JR || funct == FN_JALR) begin
        if (EN_JR != 0) begin
          dec.cls  = CLS_JR;
          dec.wsel = funct[0] ? WSEL_LINK : WSEL_ALU;
        end
      end else if (r_funct_legal(funct)) begin
        dec.cls = CLS_ALU;
      end
    end else if (op[5:1] == OP_J[5:1]) begin
      dec.cls = CLS_JUMP;
      if (op[0]) begin
        dec.wsel = WSEL_LINK;
        dec.dst  = DST_R31;
      end
    end else if (op[5:1] == OP_BEQ[5:1]) begin
      dec.cls   = CLS_BRANCH;
      dec.aluop = ALU_SUB;
      dec.bne   = op[0];
    end else if (op[5:4] == 2'b10) begin
      dec.cls     = op[3] ? CLS_STORE : CLS_LOAD;
      dec.aluop   = ALU_ADD;
      dec.alu_imm = 1'b1;
      dec.wsel    = op[3] ? WSEL_ALU : WSEL_MEM;
    end else if (op[5:3] == 3'b001) begin
      dec.cls     = CLS_ALU;
      dec.alu_imm = 1'b1;
      if (op[5:1] == OP_SLTI[5:1])
        dec.aluop = {2'b10, op[3:0]};
      else if (op == OP_LUI)
        dec.aluop = ALU_LUI;
      else
        dec.aluop = {3'b100, op[2:0]};
    end
  end

endmodule

// File: rtl/mips32i_mc_ctrl.sv
// Multi-cycle MIPS32i control FSM with a mem_req/mem_ack handshake, memory
// timeout and illegal-instruction traps, and a sticky TRAP state.
module mips32i_mc_ctrl
  import mips32i_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5,
  parameter int EN_JR       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic [2:0]  state,
  output logic [5:0]  aluop,
  output logic        inst_type_R0_I1,
  output logic        imm_signext0_zeroext1,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_wt_en,
  output logic        pc_wt_en,
  output logic [2:0]  next_PC_ctrl,
  output logic        reg_wt_en,
  output logic [1:0]  reg_wt_sel,
  output logic [1:0]  reg_dst_sel,
  output logic        trap,
  output logic [1:0]  exc_code
);

  state_e           st_q, st_d;
  exc_e             exc_q, exc_d;
  dec_t             dec, dec_q;
  npc_sel_e         npc;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             timeout_hit, in_decode;
  logic             unused_instr_bits;

  assign unused_instr_bits = ^instr[25:6];

  mips32i_decode #(.EN_JR(EN_JR)) u_decode (
    .op    (instr[31:26]),
    .funct (instr[5:0]),
    .dec   (dec)
  );

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_inc == CNT_W'(MEM_TIMEOUT));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= ST_FETCH;
      cnt_q <= '0;
      exc_q <= EXC_NONE;
      dec_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      exc_q <= exc_d;
      if (st_q == ST_DECODE) dec_q <= dec;
    end
  end

  // The wait counter only survives while the FSM stays in FETCH/MEM, so it
  // clears on every state entry.
  always_comb begin
    st_d         = st_q;
    exc_d        = exc_q;
    cnt_d        = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_wt_en     = 1'b0;
    pc_wt_en     = 1'b0;
    reg_wt_en    = 1'b0;
    npc          = NPC_SEQ;

    case (st_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_wt_en = 1'b1;
          pc_wt_en = 1'b1;
          st_d     = ST_DECODE;
        end else if (timeout_hit) begin
          st_d  = ST_TRAP;
          exc_d = EXC_FETCH_TO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DECODE: begin
        case (dec.cls)
          CLS_JUMP, CLS_JR: begin
            pc_wt_en  = 1'b1;
            npc       = (dec.cls == CLS_JR) ? NPC_REG : NPC_JUMP;
            reg_wt_en = (dec.wsel == WSEL_LINK);
            st_d      = ST_FETCH;
          end
          CLS_ILLEGAL: begin
            st_d  = ST_TRAP;
            exc_d = EXC_ILLEGAL;
          end
          default: st_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (dec_q.cls)
          CLS_BRANCH: begin
            pc_wt_en = dec_q.bne ? !alu_zero : alu_zero;
            npc      = NPC_BRANCH;
            st_d     = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: st_d = ST_MEM;
          default:             st_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (dec_q.cls == CLS_STORE);
        if (mem_ack) begin
          st_d = (dec_q.cls == CLS_STORE) ? ST_FETCH : ST_WB;
        end else if (timeout_hit) begin
          st_d  = ST_TRAP;
          exc_d = EXC_DATA_TO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WB: begin
        reg_wt_en = 1'b1;
        st_d      = ST_FETCH;
      end
      ST_TRAP: st_d = ST_TRAP;
      default: st_d = ST_FETCH;
    endcase

    // Hold the datapath quiet for as long as reset is asserted.
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_wt_en     = 1'b0;
      pc_wt_en     = 1'b0;
      reg_wt_en    = 1'b0;
      npc          = NPC_SEQ;
    end
  end

  // Decode fields are live during DECODE and held from the register after it.
  assign in_decode             = (st_q == ST_DECODE);
  assign aluop                 = in_decode ? dec.aluop   : dec_q.aluop;
  assign inst_type_R0_I1       = in_decode ? dec.alu_imm : dec_q.alu_imm;
  assign imm_signext0_zeroext1 = in_decode ? dec.zext    : dec_q.zext;
  assign reg_wt_sel            = in_decode ? dec.wsel    : dec_q.wsel;
  assign reg_dst_sel           = in_decode ? dec.dst     : dec_q.dst;

  assign state        = st_q;
  assign next_PC_ctrl = npc;
  assign trap         = (st_q == ST_TRAP);
  assign exc_code     = exc_q;

endmodule

// File: tb/tb_mips32i_mc_ctrl.sv
// Directed bench for mips32i_mc_ctrl: instruction flows, memory wait states,
// traps, reset recovery and the timeout boundary.
module tb_mips32i_mc_ctrl;
  import mips32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst, alu_zero, mem_ack;
  logic [31:0] instr;
  logic [2:0]  state, next_PC_ctrl;
  logic [5:0]  aluop;
  logic        inst_type_R0_I1, imm_signext0_zeroext1, mem_req, mem_we, mem_addr_sel;
  logic        ir_wt_en, pc_wt_en, reg_wt_en, trap;
  logic [1:0]  reg_wt_sel, reg_dst_sel, exc_code;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] I_ADD  = {OP_R, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000};
  localparam logic [31:0] I_LW   = {OP_LW, 5'd1, 5'd2, 16'h0004};
  localparam logic [31:0] I_SW   = {OP_SW, 5'd1, 5'd2, 16'h0008};
  localparam logic [31:0] I_BNE  = {OP_BNE, 5'd1, 5'd2, 16'h0010};
  localparam logic [31:0] I_JAL  = {OP_JAL, 26'h0000100};
  localparam logic [31:0] I_JR   = {OP_R, 5'd31, 15'd0, FN_JR};
  localparam logic [31:0] I_ORI  = {6'b001101, 5'd1, 5'd2, 16'h00ff};
  localparam logic [31:0] I_BAD  = 32'hfc00_0000;

  mips32i_mc_ctrl #(.MEM_TIMEOUT(4), .CNT_W(5), .EN_JR(1)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .instr                 (instr),
    .alu_zero              (alu_zero),
    .mem_ack               (mem_ack),
    .state                 (state),
    .aluop                 (aluop),
    .inst_type_R0_I1       (inst_type_R0_I1),
    .imm_signext0_zeroext1 (imm_signext0_zeroext1),
    .mem_req               (mem_req),
    .mem_we                (mem_we),
    .mem_addr_sel          (mem_addr_sel),
    .ir_wt_en              (ir_wt_en),
    .pc_wt_en              (pc_wt_en),
    .next_PC_ctrl          (next_PC_ctrl),
    .reg_wt_en             (reg_wt_en),
    .reg_wt_sel            (reg_wt_sel),
    .reg_dst_sel           (reg_dst_sel),
    .trap                  (trap),
    .exc_code              (exc_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply inputs for the current cycle and let combinational outputs settle.
  task automatic drive(input logic ack, input logic z);
    mem_ack  = ack;
    alu_zero = z;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle fetch; returns with the FSM in DECODE and mem_ack low.
  task automatic fetch(input logic [31:0] ins, input string tag);
    instr = ins;
    drive(1'b1, 1'b0);
    check({tag, "_f_state"}, state, 0);
    check({tag, "_f_ir"}, ir_wt_en, 1);
    check({tag, "_f_pc"}, pc_wt_en, 1);
    check({tag, "_f_npc"}, next_PC_ctrl, 0);
    tick();
    drive(1'b0, 1'b0);
    check({tag, "_d_state"}, state, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; instr = '0; mem_ack = 1'b0; alu_zero = 1'b0;
    tick(); tick();
    drive(1'b0, 1'b0);
    check("rst_state", state, 0);
    check("rst_req", mem_req, 0);
    check("rst_aluop", aluop, 0);
    check("rst_trap", trap, 0);
    check("rst_exc", exc_code, 0);
    rst = 1'b0;
    #1;
    check("rel_req", mem_req, 1);
    check("rel_addr", mem_addr_sel, 0);

    // ADD: FETCH, DECODE, EXEC, WB; mem_ack in EXEC must be ignored
    fetch(I_ADD, "add");
    check("add_aluop", aluop, 6'h20);
    check("add_dst", reg_dst_sel, 1);
    check("add_src", inst_type_R0_I1, 0);
    check("add_d_wen", reg_wt_en, 0);
    tick(); drive(1'b1, 1'b0);
    check("add_e_state", state, 2);
    tick(); drive(1'b0, 1'b0);
    check("add_w_state", state, 4);
    check("add_w_wen", reg_wt_en, 1);
    check("add_w_aluop", aluop, 6'h20);
    tick(); drive(1'b0, 1'b0);
    check("add_end_state", state, 0);
    check("add_end_wen", reg_wt_en, 0);

    // LW with data ack on the 4th MEM cycle (also the timeout boundary)
    fetch(I_LW, "lw");
    check("lw_aluop", aluop, 6'h20);
    check("lw_src", inst_type_R0_I1, 1);
    check("lw_zext", imm_signext0_zeroext1, 0);
    tick(); drive(1'b0, 1'b0);
    check("lw_e_state", state, 2);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(i == 3, 1'b0);
      check("lw_m_state", state, 3);
      check("lw_m_req", mem_req, 1);
      check("lw_m_addr", mem_addr_sel, 1);
      check("lw_m_we", mem_we, 0);
      tick();
    end
    drive(1'b0, 1'b0);
    check("lw_w_state", state, 4);
    check("lw_w_sel", reg_wt_sel, 1);
    check("lw_w_wen", reg_wt_en, 1);
    check("lw_w_req", mem_req, 0);
    tick(); drive(1'b0, 1'b0);
    check("lw_end_wen", reg_wt_en, 0);

    // BNE not taken (zero=1), then taken (zero=0)
    for (int k = 0; k < 2; k++) begin
      fetch(I_BNE, "bne");
      check("bne_aluop", aluop, 6'h22);
      tick(); drive(1'b0, k == 0);
      check("bne_e_state", state, 2);
      check("bne_pc", pc_wt_en, (k == 0) ? 0 : 1);
      if (k == 1) check("bne_npc", next_PC_ctrl, 2);
      tick(); drive(1'b0, 1'b0);
      check("bne_end_state", state, 0);
    end

    // JAL resolves in DECODE with a link write to $31
    fetch(I_JAL, "jal");
    check("jal_pc", pc_wt_en, 1);
    check("jal_npc", next_PC_ctrl, 1);
    check("jal_wen", reg_wt_en, 1);
    check("jal_sel", reg_wt_sel, 2);
    check("jal_dst", reg_dst_sel, 2);
    tick(); drive(1'b0, 1'b0);
    check("jal_end_state", state, 0);
    check("jal_hold_sel", reg_wt_sel, 2);
    check("jal_end_wen", reg_wt_en, 0);

    // JR: PC from rs, no register write
    fetch(I_JR, "jr");
    check("jr_npc", next_PC_ctrl, 3);
    check("jr_pc", pc_wt_en, 1);
    check("jr_wen", reg_wt_en, 0);
    tick(); drive(1'b0, 1'b0);
    check("jr_end_state", state, 0);

    // ORI: zero-extended immediate, rt destination
    fetch(I_ORI, "ori");
    check("ori_aluop", aluop, 6'h25);
    check("ori_zext", imm_signext0_zeroext1, 1);
    check("ori_src", inst_type_R0_I1, 1);
    check("ori_dst", reg_dst_sel, 0);
    tick(); tick(); drive(1'b0, 1'b0);
    check("ori_w_state", state, 4);
    tick(); drive(1'b0, 1'b0);

    // Illegal opcode: sticky TRAP, ack ignored, only reset leaves it
    fetch(I_BAD, "bad");
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1);
      check("bad_state", state, 7);
      check("bad_trap", trap, 1);
      check("bad_exc", exc_code, 1);
      check("bad_req", mem_req, 0);
      check("bad_strb", {ir_wt_en, pc_wt_en, reg_wt_en}, 0);
      tick();
    end
    rst = 1'b1;
    tick(); drive(1'b0, 1'b0);
    check("rst2_state", state, 0);
    check("rst2_trap", trap, 0);
    check("rst2_exc", exc_code, 0);
    check("rst2_req", mem_req, 0);
    check("rst2_sel", reg_wt_sel, 0);
    rst = 1'b0;

    // Fetch timeout: 4 wait cycles with no ack, then TRAP code 2
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0);
      check("fto_state", state, 0);
      check("fto_req", mem_req, 1);
      tick();
    end
    drive(1'b0, 1'b0);
    check("fto_trap_state", state, 7);
    check("fto_exc", exc_code, 2);

    // Ack on the 4th fetch cycle completes normally; then a data timeout
    rst = 1'b1;
    tick();
    rst = 1'b0;
    instr = I_SW;
    for (int i = 0; i < 4; i++) begin
      drive(i == 3, 1'b0);
      check("fack_state", state, 0);
      tick();
    end
    drive(1'b0, 1'b0);
    check("fack_decode", state, 1);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0);
      check("dto_state", state, 3);
      check("dto_we", mem_we, 1);
      tick();
    end
    drive(1'b0, 1'b0);
    check("dto_trap_state", state, 7);
    check("dto_exc", exc_code, 3);

    // Store with 1-cycle ack returns from MEM straight to FETCH
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fetch(I_SW, "sw");
    tick(); tick(); drive(1'b1, 1'b0);
    check("sw_m_state", state, 3);
    check("sw_m_we", mem_we, 1);
    tick(); drive(1'b0, 1'b0);
    check("sw_end_state", state, 0);
    check("sw_end_wen", reg_wt_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
